// File: rtl/load_store_unit.sv
// Load/store unit: turns one execute-stage memory request into one or two
// word-aligned bus beats, merging and extending split loads.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemWrite,
    input  logic [1:0]            length,
    input  logic                  signExt,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BEAT0 = 2'b01,
        BEAT1 = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t                  state_q;
    logic                    we_q;
    logic                    sext_q;
    logic [1:0]              len_q;
    logic [1:0]              off_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   lo_q;
    logic                    ready_q;
    logic                    done_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [3:0]              mem_be_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    split_d;
    logic                    finish_d;
    logic [DATA_WIDTH-1:0]   load_res_d;

    function automatic logic [3:0] mask_f(input logic [1:0] len);
        case (len)
            2'b00:   mask_f = 4'b0001;
            2'b01:   mask_f = 4'b0011;
            default: mask_f = 4'b1111;
        endcase
    endfunction

    // A half splits only at offset 3; a word splits at any non-zero offset.
    function automatic logic split_f(input logic [1:0] len, input logic [1:0] off);
        case (len)
            2'b00:   split_f = 1'b0;
            2'b01:   split_f = (off == 2'b11);
            default: split_f = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] be_lo_f(input logic [1:0] len, input logic [1:0] off);
        be_lo_f = mask_f(len) << off;
    endfunction

    function automatic logic [3:0] be_hi_f(input logic [1:0] len, input logic [1:0] off);
        be_hi_f = mask_f(len) >> (3'd4 - {1'b0, off});
    endfunction

    function automatic logic [31:0] lane_lo_f(input logic [31:0] d, input logic [1:0] off);
        lane_lo_f = d << {off, 3'b000};
    endfunction

    function automatic logic [31:0] lane_hi_f(input logic [31:0] d, input logic [1:0] off);
        lane_hi_f = d >> {(3'd4 - {1'b0, off}), 3'b000};
    endfunction

    // Realign {hi, lo} so the addressed byte sits in lane 0, then extend.
    function automatic logic [31:0] merge_f(input logic [31:0] hi, input logic [31:0] lo,
                                            input logic [1:0] off, input logic [1:0] len,
                                            input logic zext);
        logic [31:0] v;
        v = (lo >> {off, 3'b000}) | (hi << {(3'd4 - {1'b0, off}), 3'b000});
        case (len)
            2'b00:   merge_f = zext ? {24'h000000, v[7:0]} : {{24{v[7]}}, v[7:0]};
            2'b01:   merge_f = zext ? {16'h0000, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: merge_f = v;
        endcase
    endfunction

    // Completion decode and load result for the beat being acknowledged.
    always_comb begin
        split_d    = split_f(len_q, off_q);
        finish_d   = 1'b0;
        load_res_d = 32'h0000_0000;
        if (state_q == BEAT1) begin
            finish_d   = mem_ack;
            load_res_d = merge_f(mem_rdata, lo_q, off_q, len_q, sext_q);
        end else if (state_q == BEAT0) begin
            finish_d   = mem_ack & ~split_d;
            load_res_d = merge_f(32'h0000_0000, mem_rdata, off_q, len_q, sext_q);
        end else begin
            finish_d   = 1'b0;
            load_res_d = 32'h0000_0000;
        end
    end

    // Access sequencer with all bus and result outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            sext_q      <= 1'b0;
            len_q       <= 2'b00;
            off_q       <= 2'b00;
            wdata_q     <= 32'h0000_0000;
            lo_q        <= 32'h0000_0000;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            rdata_q     <= 32'h0000_0000;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= MemWrite;
                        sext_q      <= signExt;
                        len_q       <= length;
                        off_q       <= addr[1:0];
                        wdata_q     <= wdata;
                        ready_q     <= 1'b0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= MemWrite;
                        mem_be_q    <= be_lo_f(length, addr[1:0]);
                        mem_addr_q  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_q <= lane_lo_f(wdata, addr[1:0]);
                        state_q     <= BEAT0;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                BEAT0: begin
                    if (mem_ack) begin
                        lo_q <= mem_rdata;
                    end else begin
                        lo_q <= lo_q;
                    end
                    if (mem_ack && split_d) begin
                        mem_be_q    <= be_hi_f(len_q, off_q);
                        mem_addr_q  <= mem_addr_q + 32'd4;
                        mem_wdata_q <= lane_hi_f(wdata_q, off_q);
                        state_q     <= BEAT1;
                    end else begin
                        state_q <= BEAT0;
                    end
                end
                BEAT1: begin
                    state_q <= BEAT1;
                end
                DONE: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q   <= 1'b1;
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
            // Last beat acknowledged: release the bus and publish the result.
            if (finish_d) begin
                state_q     <= DONE;
                done_q      <= 1'b1;
                mem_req_q   <= 1'b0;
                mem_we_q    <= 1'b0;
                mem_be_q    <= 4'b0000;
                mem_addr_q  <= 32'h0000_0000;
                mem_wdata_q <= 32'h0000_0000;
                if (!we_q) begin
                    rdata_q <= load_res_d;
                end else begin
                    rdata_q <= rdata_q;
                end
            end else begin
                rdata_q <= rdata_q;
            end
        end
    end

    assign req_ready = ready_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access unit between the execute stage and a word-wide data memory bus. It consumes the memory control fields the control unit decodes from load/store instructions (MemWrite, length, signExt) plus the ALU-computed address and store data. It issues one or two word-aligned bus transactions, with byte enables for stores and lane extraction plus extension for loads. Accesses that cross a word boundary are split into two beats and merged transparently.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; only 32 is supported

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  access request from execute stage
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready
- MemWrite  input  1  1 = store, 0 = load
- length  input  2  00 = byte, 01 = half, 10 = word, 11 = treated as word
- signExt  input  1  loads only: 0 = sign-extend, 1 = zero-extend (control unit drives 1 for LBU/LHU)
- addr  input  32  byte address, any alignment
- wdata  input  32  store data, right-justified
- done  output  1  one-cycle pulse at completion of an accepted access
- rdata  output  32  extended load result; valid with done and held until the next done
- mem_req  output  1  bus request, held until mem_ack
- mem_we  output  1  bus write enable
- mem_be  output  4  byte enables; bit i = byte lane i (little-endian)
- mem_addr  output  32  word-aligned bus address; bits [1:0] = 00
- mem_wdata  output  32  lane-aligned write data
- mem_rdata  input  32  read data, valid in the cycle of mem_ack
- mem_ack  input  1  beat completion; may be asserted in the first cycle mem_req is high

## Operation
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE: req_ready = 1. On accept, register addr, wdata, length, signExt and MemWrite, then go to BEAT0. Input fields are don't-care after acceptance.
- Access size: n = 1, 2 or 4 bytes. Offset: off = addr[1:0]. The access splits when off + n > 4.
- BEAT0: mem_addr = {addr[31:2], 00}. mem_be = (2^n − 1) << off, truncated to 4 bits. mem_wdata = wdata << 8·off.
- On BEAT0 mem_ack: capture mem_rdata into lo. If split, go to BEAT1; otherwise go to DONE.
- BEAT1: mem_addr = {addr[31:2], 00} + 4, wrapping modulo 2^32. mem_be = (2^n − 1) >> (4 − off). mem_wdata = wdata >> 8·(4 − off).
- On BEAT1 mem_ack: capture mem_rdata into hi and go to DONE.
- mem_we equals the registered MemWrite in both beats. mem_req = 1 exactly in BEAT0 and BEAT1.
- Address, enable and data outputs stay stable while mem_req is high and mem_ack is low.
- Load merge: take the low n bytes of {hi, lo} >> 8·off. If not split, hi is don't-care.
- Load extension: byte/half loads sign- or zero-extend per the registered signExt; word loads are passed through unchanged.
- DONE: done = 1. rdata updates on loads; on stores rdata holds its previous value. Next state is IDLE; req_ready = 0 in DONE.
- req_valid outside IDLE is ignored and is not queued.

## Timing
- Reset (async): state = IDLE. mem_req = 0, mem_we = 0, mem_be = 0000, mem_addr = 0, mem_wdata = 0, done = 0, rdata = 0, req_ready = 1.
- Reset mid-access abandons the bus beat immediately (mem_req drops without waiting for ack); no done pulse.
- Zero-wait memory (ack in first req cycle):
  - aligned: accept at cycle t, BEAT0 at t+1, done at t+2; next accept earliest t+3.
  - split: BEAT0 at t+1, BEAT1 at t+2, done at t+3.
- Each wait cycle (mem_req high, mem_ack low) adds exactly one cycle.
- mem_ack while mem_req = 0 is ignored.
- All outputs are registered or decoded from registered state only; there is no combinational path from req_valid to mem_*.

## Test plan
- Aligned LW, addr 0x100, memory word 0xDEADBEEF, zero-wait → one beat: mem_addr 0x100, be 1111; done at t+2; rdata 0xDEADBEEF.
- LB addr 0x203, word 0x80xxxxxx, signExt 0 → be 1000; rdata 0xFFFFFF80. Same access with signExt 1 → rdata 0x00000080.
- LHU addr 0x103, words 0xAB000000 at 0x100 and 0x000000CD at 0x104 → beat0 be 1000, beat1 be 0001 at 0x104; done at t+3; rdata 0x0000CDAB.
- SW addr 0x302, wdata 0x11223344 → beat0 mem_addr 0x300, be 1100, mem_wdata[31:16] = 0x3344; beat1 mem_addr 0x304, be 0011, mem_wdata[15:0] = 0x1122; mem_we 1 both beats.
- Aligned SB addr 0x10 with mem_ack delayed 3 cycles → mem_req/addr/be/wdata stable for 4 cycles; done at t+5; a req_valid pulse during the access is ignored.
- Split load at addr 0xFFFFFFFE → beat1 mem_addr 0x00000000. Repeat the access and assert rst during BEAT1 → mem_req 0 in the same cycle, no done pulse, req_ready 1 after rst release.
